// File: rtl/btn_scan_ctrl_pkg.sv
// Shared definitions for the front-panel button scanner: event encodings,
// default parameter values and a counter-width helper.
package btn_scan_ctrl_pkg;

  typedef enum logic {
    EVT_PRESS   = 1'b0,
    EVT_RELEASE = 1'b1
  } evt_type_e;

  localparam int DEF_N_BTN        = 4;
  localparam int DEF_ID_W         = 2;
  localparam int DEF_TICK_CYCLES  = 1250000;
  localparam int DEF_HIST         = 4;
  localparam int DEF_REPEAT_TICKS = 32;

  // Width of a counter holding 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_scan_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr,
// wrapping, reported as one-hot grant plus binary index.
module btn_scan_ctrl_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int cand;
    cand = 0;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    for (int off = 0; off < N; off++) begin
      cand = int'(ptr) + off;
      if (cand >= N) cand = cand - N;
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/btn_scan_ctrl.sv
// Multi-button debouncer with per-button pending events drained round-robin
// onto one valid/ready port. Optional auto-repeat: BTN_AUTO_REPEAT_EN.
module btn_scan_ctrl
  import btn_scan_ctrl_pkg::*;
#(
  parameter int N_BTN        = DEF_N_BTN,
  parameter int ID_W         = DEF_ID_W,
  parameter int TICK_CYCLES  = DEF_TICK_CYCLES,
  parameter int HIST         = DEF_HIST,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] stable_out,
  output logic             tick_out,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [ID_W-1:0]  evt_id,
  output logic             evt_release,
  output logic [N_BTN-1:0] overrun,
  input  logic             ovr_clr
);

  localparam int CNT_W = cnt_w(TICK_CYCLES);

  if (N_BTN < 1 || N_BTN > 16 || HIST < 2 || HIST > 8 ||
      TICK_CYCLES < 2 || REPEAT_TICKS < 1) begin : g_bad_params
    $error("btn_scan_ctrl: parameter out of range");
  end

  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic [HIST-1:0]  hist [N_BTN];
  logic [N_BTN-1:0] press_trans, rel_trans, rep_evt, evt_set, evt_type;
  logic [N_BTN-1:0] pending, ptype, gnt, issue;
  logic [ID_W-1:0]  rr_ptr, gnt_idx;
  logic             gnt_any, load;

  assign tick     = (tick_cnt == CNT_W'(TICK_CYCLES - 1));
  assign tick_out = tick;

  always_ff @(posedge clk) begin
    if (rst || tick) tick_cnt <= '0;
    else             tick_cnt <= tick_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_BTN; i++) begin
      if (rst)       hist[i] <= '0;
      else if (tick) hist[i] <= {hist[i][HIST-2:0], btn_in[i]};
    end
  end

  always_comb begin
    press_trans = '0;
    rel_trans   = '0;
    evt_type    = '0;
    for (int i = 0; i < N_BTN; i++) begin
      press_trans[i] = (&hist[i]) && !stable_out[i];
      rel_trans[i]   = (~|hist[i]) && stable_out[i];
      evt_type[i]    = rel_trans[i] ? EVT_RELEASE : EVT_PRESS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stable_out <= '0;
    else     stable_out <= (stable_out | press_trans) & ~rel_trans;
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam int REP_W = cnt_w(REPEAT_TICKS + 1);
  logic [REP_W-1:0] rep_cnt [N_BTN];

  always_comb begin
    rep_evt = '0;
    for (int i = 0; i < N_BTN; i++)
      rep_evt[i] = stable_out[i] && tick && (rep_cnt[i] == REP_W'(REPEAT_TICKS - 1));
  end

  // Counter restarts on each press and is held clear while released.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_BTN; i++) begin
      if (rst || press_trans[i] || !stable_out[i]) rep_cnt[i] <= '0;
      else if (tick)                               rep_cnt[i] <= rep_evt[i] ? '0 : rep_cnt[i] + REP_W'(1);
    end
  end
`else
  assign rep_evt = '0;
`endif

  assign evt_set = press_trans | rel_trans | rep_evt;
  assign load    = !evt_valid || evt_ready;
  assign issue   = (load && gnt_any) ? gnt : '0;

  btn_scan_ctrl_rr_arbiter #(
    .N     (N_BTN),
    .IDX_W (ID_W)
  ) u_arb (
    .req (pending),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  // A fresh transition beats the grant that would clear its pending slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      ptype   <= '0;
      overrun <= '0;
    end else begin
      pending <= (pending & ~issue) | evt_set;
      ptype   <= (ptype & ~evt_set) | (evt_type & evt_set);
      overrun <= (ovr_clr ? '0 : overrun) | (evt_set & pending & ~issue);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid   <= 1'b0;
      evt_id      <= '0;
      evt_release <= 1'b0;
      rr_ptr      <= '0;
    end else if (load) begin
      evt_valid <= gnt_any;
      if (gnt_any) begin
        evt_id      <= gnt_idx;
        evt_release <= ptype[gnt_idx];
        rr_ptr      <= (gnt_idx == ID_W'(N_BTN - 1)) ? '0 : gnt_idx + ID_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_btn_scan_ctrl.sv
// Directed testbench for btn_scan_ctrl with a 4-cycle tick and 4-sample history.
// Define BTN_AUTO_REPEAT_EN to run the auto-repeat scenario instead.
module tb_btn_scan_ctrl;

  localparam int N_BTN        = 4;
  localparam int ID_W         = 2;
  localparam int TICK_CYCLES  = 4;
  localparam int HIST         = 4;
  localparam int REPEAT_TICKS = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] stable_out;
  logic             tick_out;
  logic             evt_valid;
  logic             evt_ready;
  logic [ID_W-1:0]  evt_id;
  logic             evt_release;
  logic [N_BTN-1:0] overrun;
  logic             ovr_clr;

  int total = 0;
  int bad   = 0;
  int press_cnt = 0;
  int rel_cnt   = 0;

  always #5 clk = ~clk;

  btn_scan_ctrl #(
    .N_BTN        (N_BTN),
    .ID_W         (ID_W),
    .TICK_CYCLES  (TICK_CYCLES),
    .HIST         (HIST),
    .REPEAT_TICKS (REPEAT_TICKS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn_in),
    .stable_out  (stable_out),
    .tick_out    (tick_out),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_id      (evt_id),
    .evt_release (evt_release),
    .overrun     (overrun),
    .ovr_clr     (ovr_clr)
  );

  // Single point of comparison: counts every check, reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N_BTN-1:0] b, input logic rdy, input logic clr);
    btn_in    = b;
    evt_ready = rdy;
    ovr_clr   = clr;
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  // Steps up to the next tick cycle, then across its active edge.
  task automatic waitTick();
    int n;
    n = 0;
    while (tick_out !== 1'b1 && n < 2 * TICK_CYCLES) begin
      stepClk();
      n++;
    end
    if (tick_out !== 1'b1) checkOutput("tick_timeout", {31'd0, tick_out}, 32'd1);
    stepClk();
  endtask

  task automatic runTicks(input int n);
    repeat (n) waitTick();
  endtask

  task automatic checkEvt(input string tag, input logic v, input logic [ID_W-1:0] id, input logic rel);
    checkOutput({tag, "_valid"}, {31'd0, evt_valid}, {31'd0, v});
    if (v) begin
      checkOutput({tag, "_id"}, {30'd0, evt_id}, {30'd0, id});
      checkOutput({tag, "_rel"}, {31'd0, evt_release}, {31'd0, rel});
    end
  endtask

  task automatic stepWatch();
    stepClk();
    if (evt_valid && evt_ready) begin
      if (evt_release) rel_cnt++;
      else             press_cnt++;
    end
  endtask

  task automatic tickWatch();
    int n;
    n = 0;
    while (tick_out !== 1'b1 && n < 2 * TICK_CYCLES) begin
      stepWatch();
      n++;
    end
    if (tick_out !== 1'b1) checkOutput("tick_timeout", {31'd0, tick_out}, 32'd1);
    stepWatch();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    applyStimulus('0, 1'b1, 1'b0);
    rst = 1'b1;
    stepClk();
    stepClk();
    checkOutput("rst_stable", {28'd0, stable_out}, 32'd0);
    checkOutput("rst_valid", {31'd0, evt_valid}, 32'd0);
    checkOutput("rst_id", {30'd0, evt_id}, 32'd0);
    checkOutput("rst_rel", {31'd0, evt_release}, 32'd0);
    checkOutput("rst_ovr", {28'd0, overrun}, 32'd0);
    checkOutput("rst_tick", {31'd0, tick_out}, 32'd0);

`ifdef BTN_AUTO_REPEAT_EN
    applyStimulus(4'b0001, 1'b1, 1'b0);
    rst = 1'b0;
    runTicks(4);
    checkOutput("rep_pre_stable", {28'd0, stable_out}, 32'd0);
    stepWatch();
    checkOutput("rep_stable", {28'd0, stable_out}, 32'd1);
    for (int k = 1; k <= 7; k++) tickWatch();
    checkOutput("rep_hold_press", press_cnt, 32'd4);
    checkOutput("rep_hold_rel", rel_cnt, 32'd0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    for (int k = 8; k <= 14; k++) tickWatch();
    repeat (4) stepWatch();
    checkOutput("rep_total_press", press_cnt, 32'd6);
    checkOutput("rep_total_rel", rel_cnt, 32'd1);
    checkOutput("rep_end_stable", {28'd0, stable_out}, 32'd0);
    checkOutput("rep_end_valid", {31'd0, evt_valid}, 32'd0);
`else
    applyStimulus(4'b0001, 1'b1, 1'b0);
    rst = 1'b0;
    stepClk();
    checkOutput("cnt_c1", {31'd0, tick_out}, 32'd0);
    stepClk();
    checkOutput("cnt_c2", {31'd0, tick_out}, 32'd0);
    stepClk();
    checkOutput("cnt_c3", {31'd0, tick_out}, 32'd1);

    // Single press: stable one clock after the 4th tick, event one clock later.
    for (int i = 0; i < HIST; i++) begin
      checkOutput("p0_pre_stable", {28'd0, stable_out}, 32'd0);
      waitTick();
    end
    checkOutput("p0_hist_full", {28'd0, stable_out}, 32'd0);
    stepClk();
    checkOutput("p0_stable", {28'd0, stable_out}, 32'd1);
    checkOutput("p0_not_yet", {31'd0, evt_valid}, 32'd0);
    stepClk();
    checkEvt("p0_evt", 1'b1, 2'd0, 1'b0);
    stepClk();
    checkEvt("p0_idle", 1'b0, 2'd0, 1'b0);

    // Bouncing button never settles.
    for (int t = 0; t < 12; t++) begin
      btn_in[1] = logic'((t / 3) % 2);
      waitTick();
      checkOutput("bounce_stable", {28'd0, stable_out}, 32'd1);
      checkOutput("bounce_valid", {31'd0, evt_valid}, 32'd0);
    end
    btn_in[1] = 1'b0;
    runTicks(4);
    checkOutput("bounce_end", {28'd0, stable_out}, 32'd1);

    // Held event, payload stability, then reset mid-handshake.
    applyStimulus(4'b0000, 1'b0, 1'b0);
    runTicks(4);
    stepClk();
    checkOutput("r0_stable", {28'd0, stable_out}, 32'd0);
    stepClk();
    checkEvt("r0_evt", 1'b1, 2'd0, 1'b1);
    stepClk();
    checkEvt("r0_hold", 1'b1, 2'd0, 1'b1);
    rst = 1'b1;
    stepClk();
    checkOutput("mid_rst_valid", {31'd0, evt_valid}, 32'd0);
    checkOutput("mid_rst_rel", {31'd0, evt_release}, 32'd0);
    checkOutput("mid_rst_tick", {31'd0, tick_out}, 32'd0);
    rst = 1'b0;
    evt_ready = 1'b1;
    stepClk();
    checkOutput("mid_rst_c1", {31'd0, tick_out}, 32'd0);
    checkOutput("mid_rst_dropped", {31'd0, evt_valid}, 32'd0);
    stepClk();
    checkOutput("mid_rst_c2", {31'd0, tick_out}, 32'd0);
    stepClk();
    checkOutput("mid_rst_c3", {31'd0, tick_out}, 32'd1);

    // Simultaneous batch with pointer at 0.
    applyStimulus(4'b1101, 1'b1, 1'b0);
    runTicks(4);
    stepClk();
    checkOutput("b1_stable", {28'd0, stable_out}, 32'hD);
    checkOutput("b1_not_yet", {31'd0, evt_valid}, 32'd0);
    stepClk();
    checkEvt("b1_e0", 1'b1, 2'd0, 1'b0);
    stepClk();
    checkEvt("b1_e1", 1'b1, 2'd2, 1'b0);
    stepClk();
    checkEvt("b1_e2", 1'b1, 2'd3, 1'b0);
    stepClk();
    checkEvt("b1_idle", 1'b0, 2'd0, 1'b0);

    applyStimulus(4'b0000, 1'b1, 1'b0);
    runTicks(4);
    stepClk();
    checkOutput("b2_stable", {28'd0, stable_out}, 32'd0);
    stepClk();
    checkEvt("b2_e0", 1'b1, 2'd0, 1'b1);
    stepClk();
    checkEvt("b2_e1", 1'b1, 2'd2, 1'b1);
    stepClk();
    checkEvt("b2_e2", 1'b1, 2'd3, 1'b1);
    stepClk();
    checkEvt("b2_idle", 1'b0, 2'd0, 1'b0);

    applyStimulus(4'b1001, 1'b1, 1'b0);
    runTicks(4);
    stepClk();
    checkOutput("b3_stable", {28'd0, stable_out}, 32'h9);
    stepClk();
    checkEvt("b3_e0", 1'b1, 2'd0, 1'b0);
    stepClk();
    checkEvt("b3_e1", 1'b1, 2'd3, 1'b0);
    stepClk();
    checkEvt("b3_idle", 1'b0, 2'd0, 1'b0);

    // Overrun: button 1 presses then releases while the port is stalled.
    applyStimulus(4'b1010, 1'b0, 1'b0);
    runTicks(4);
    stepClk();
    checkOutput("ov_stable1", {28'd0, stable_out}, 32'hA);
    checkOutput("ov_none_yet", {28'd0, overrun}, 32'd0);
    stepClk();
    checkEvt("ov_held", 1'b1, 2'd0, 1'b1);
    btn_in = 4'b1000;
    runTicks(4);
    stepClk();
    checkOutput("ov_stable2", {28'd0, stable_out}, 32'h8);
    checkOutput("ov_set", {28'd0, overrun}, 32'h2);
    checkEvt("ov_still_held", 1'b1, 2'd0, 1'b1);
    stepClk();
    checkOutput("ov_sticky", {28'd0, overrun}, 32'h2);
    evt_ready = 1'b1;
    stepClk();
    checkEvt("ov_e1", 1'b1, 2'd1, 1'b1);
    stepClk();
    checkEvt("ov_idle", 1'b0, 2'd0, 1'b0);
    checkOutput("ov_before_clr", {28'd0, overrun}, 32'h2);
    ovr_clr = 1'b1;
    stepClk();
    checkOutput("ov_cleared", {28'd0, overrun}, 32'd0);
    ovr_clr = 1'b0;
    stepClk();
    checkOutput("ov_stays_clear", {28'd0, overrun}, 32'd0);
    checkOutput("ov_no_extra", {31'd0, evt_valid}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
